// File: rtl/md_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: widths, funct3/funct7
// decodes and the one-hot FSM state encoding.
package md_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = 5;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [4:0] ST_IDLE = 5'b00001;
    localparam logic [4:0] ST_MUL  = 5'b00010;
    localparam logic [4:0] ST_DIV  = 5'b00100;
    localparam logic [4:0] ST_FIX  = 5'b01000;
    localparam logic [4:0] ST_DONE = 5'b10000;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate; used as abs() on operands and as the
// sign correction on product, quotient and remainder.
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] data,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? ((~data) + W'(1)) : data;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one result bit per cycle, with divide-by-zero / overflow fast path.
module muldiv_sequencer
    import md_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_E,
    input  logic [2:0]      funct3_E,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush_E,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [4:0]        state_reg;
    logic [CNT_W-1:0]  counter_reg;
    logic [2:0]        funct3_reg;
    logic              sign_a_reg;
    logic              sign_b_reg;
    logic [XLEN-1:0]   opnd_b_reg;
    // Multiply: {hi accumulator, multiplier}. Divide: {remainder, quotient}.
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   result_reg;

    logic accept;
    logic signed_a, signed_b;
    logic [XLEN-1:0] operand [2];
    logic            neg_in  [2];
    logic [XLEN-1:0] mag     [2];

    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (funct3_E)
            F3_MULH, F3_DIV, F3_REM: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            F3_MULHSU: signed_a = 1'b1;
            default: ;
        endcase
    end

    assign operand[0] = src_a;
    assign operand[1] = src_b;
    assign neg_in[0]  = signed_a & src_a[XLEN-1];
    assign neg_in[1]  = signed_b & src_b[XLEN-1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_abs
            md_sign_fix #(.W(XLEN)) u_abs (
                .data   (operand[gi]),
                .negate (neg_in[gi]),
                .result (mag[gi])
            );
        end
    endgenerate

    // Fast path: results that need no iteration (and would overflow the FIX step).
    logic [XLEN-1:0] min_int;
    logic div_zero, div_ovf, fast_path;
    logic [XLEN-1:0] fast_result;

    assign min_int   = {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero  = funct3_E[2] && (src_b == '0);
    assign div_ovf   = funct3_E[2] && !funct3_E[0] && (src_a == min_int) && (src_b == '1);
    assign fast_path = div_zero || div_ovf;
    always_comb begin
        if (div_zero)
            fast_result = funct3_E[1] ? src_a : '1;
        else
            fast_result = funct3_E[1] ? '0 : min_int;
    end

    // Shift-add multiply step
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_b_reg} : '0);
    assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

    // Restoring divide step; 33-bit partial remainder since 2*rem+1 can exceed XLEN bits
    logic [XLEN:0]     rem_shift;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] div_next;
    assign rem_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    assign rem_ge    = rem_shift >= {1'b0, opnd_b_reg};
    assign rem_sub   = rem_shift[XLEN-1:0] - opnd_b_reg;
    assign div_next  = {(rem_ge ? rem_sub : rem_shift[XLEN-1:0]), acc_reg[XLEN-2:0], rem_ge};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

    md_sign_fix #(.W(2*XLEN)) u_fix_prod (
        .data   (acc_reg),
        .negate (sign_a_reg ^ sign_b_reg),
        .result (prod_fix)
    );

    md_sign_fix #(.W(XLEN)) u_fix_quot (
        .data   (acc_reg[XLEN-1:0]),
        .negate (sign_a_reg ^ sign_b_reg),
        .result (quot_fix)
    );

    // Remainder follows the dividend's sign
    md_sign_fix #(.W(XLEN)) u_fix_rem (
        .data   (acc_reg[2*XLEN-1:XLEN]),
        .negate (sign_a_reg),
        .result (rem_fix)
    );

    always_comb begin
        fix_result = rem_fix;
        case (funct3_reg)
            F3_MUL:                       fix_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_result = quot_fix;
            default:                      fix_result = rem_fix;
        endcase
    end

    assign accept = (state_reg == ST_IDLE) && start_E && !flush_E;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            counter_reg <= '0;
            funct3_reg  <= '0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            opnd_b_reg  <= '0;
            acc_reg     <= '0;
            result_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        funct3_reg  <= funct3_E;
                        sign_a_reg  <= neg_in[0];
                        sign_b_reg  <= neg_in[1];
                        opnd_b_reg  <= mag[1];
                        acc_reg     <= {{XLEN{1'b0}}, mag[0]};
                        counter_reg <= '0;
                        if (fast_path) begin
                            result_reg <= fast_result;
                            state_reg  <= ST_DONE;
                        end else begin
                            state_reg  <= funct3_E[2] ? ST_DIV : ST_MUL;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (flush_E) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        acc_reg     <= (state_reg == ST_MUL) ? mul_next : div_next;
                        counter_reg <= counter_reg + CNT_W'(1);
                        if (counter_reg == '1)
                            state_reg <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (flush_E) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        result_reg <= fix_result;
                        state_reg  <= ST_DONE;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (state_reg == ST_MUL) || (state_reg == ST_DIV) || (state_reg == ST_FIX) || accept;
    assign done   = (state_reg == ST_DONE);
    assign result = result_reg;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its sequencing FSM. Sits beside the ALU in the EX stage.
- Accepts one M-extension operation (opcode 0110011, funct7 0000001) and stalls the pipeline via busy while it computes.
- Returns a 32-bit result with a one-cycle done strobe.
- Shift-add multiply and restoring divide; one result bit per cycle.

Parameters:
XLEN, 32, operand/result width
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start_E  in  1  EX holds a valid M-extension op; sampled only in IDLE
funct3_E  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  in  XLEN  rs1 operand (forwarded)
src_b  in  XLEN  rs2 operand (forwarded)
flush_E  in  1  kill the in-flight op (branch/jump redirect)
busy  out  1  stall request to hazard unit
done  out  1  result valid, exactly one cycle
result  out  XLEN  operation result

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, acc/quotient/remainder/result=0, done=0, busy=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE + start_E & !flush_E:
  - Latch funct3, operand magnitudes and sign flags. Signedness: MULH both operands signed; MULHSU only src_a signed; DIV/REM signed.
  - Next state DIV for funct3[2]=1, else MUL. counter=0.
- Fast path (from IDLE, skips MUL/DIV/FIX):
  - Divide by zero (src_b=0): DIV/DIVU → 0xFFFFFFFF; REM/REMU → src_a.
  - Signed overflow (DIV/REM, src_a=0x80000000, src_b=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
  - Next state DONE.
- MUL: 64-bit product register. Each cycle: if multiplier LSB=1 add multiplicand to upper half, then shift right 1. After counter=31 → FIX.
- DIV: restoring. Each cycle: shift {rem,quot} left 1; if rem ≥ divisor, subtract and set quot LSB. After counter=31 → FIX.
- FIX (1 cycle):
  - MUL: negate 64-bit product if sign flags differ.
  - DIV: negate quotient if sign flags differ; remainder takes the dividend's sign.
  - Select low word (MUL) or high word (MULH*), or quotient/remainder. Register into result. → DONE.
- DONE (1 cycle): done=1. → IDLE.
- result holds its value until the next FIX or fast-path completion.
- Latency, start sampled in cycle N:
  - normal ops: done in cycle N+34;
  - fast path: done in cycle N+1.
- busy (combinational): 1 in MUL/DIV/FIX, and in IDLE when start_E & !flush_E is sampled; 0 in DONE, so EX advances and captures result that cycle.
- Boundary conditions:
  - start_E outside IDLE: ignored; no queuing.
  - flush_E in any state except DONE: next state IDLE, no done, busy=0 from the next cycle, result unchanged.
  - flush_E in DONE: done still asserts (the op was already accepted by WB).
  - start_E and flush_E together in IDLE: not accepted.
  - counter wraps 31→0 only on the FIX transition.
  - rst mid-op: immediate IDLE, no done.
- All arithmetic is unsigned on magnitudes. Negation is two's complement at operand width (64 for product, 32 otherwise). Overflow in FIX is impossible after the fast-path filter.

Decomposition:
- Shared package md_pkg:
  - funct3 localparams (MUL..REMU);
  - M-extension funct7 constant 7'b0000001;
  - state encoding (one-hot, 5 bits);
  - XLEN.
- One sub-module, md_sign_fix: combinational magnitude/negate helper (abs of operand given a signed flag; conditional 64-bit negate). Instantiated for operand prep and for FIX.
- FSM, counter and shift registers stay in the top.

Test Plan:
- MUL src_a=7, src_b=0xFFFFFFFD → result 0xFFFFFFEB, done at start+34; busy high cycles start..start+33, low at start+34.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7÷2 → 0xFFFFFFFD; REM −7÷2 → 0xFFFFFFFF; DIVU 100÷7 → 14; REMU 100÷7 → 2.
- DIV 5÷0 → 0xFFFFFFFF, done at start+1; REM 5÷0 → 5; DIV 0x80000000÷0xFFFFFFFF → 0x80000000; REM of the same → 0.
- flush_E at iteration 10 of DIV → no done, busy 0 next cycle; following MUL 3×4 → 12 with normal latency. start_E pulses while busy → ignored.
- rst asserted mid-MUL (async, between edges) → busy/done/result 0 immediately; a fresh op after reset release completes correctly.
